// File: rtl/gshare_branch_predictor.sv
// Bimodal/gshare branch predictor: PHT of saturating counters indexed by PC (optionally XOR GHR),
// speculative global history with repair on mispredict, and resolved-branch statistics.
module gshare_branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int HIST_BITS  = 6,
  parameter int MODE       = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            pred_valid,
  input  logic                            pred_kill,
  input  logic [31:0]                     pred_pc,
  input  logic [31:0]                     pred_offset,
  output logic [31:0]                     pred_target,
  output logic                            pred_taken,
  output logic [HIST_BITS+INDEX_BITS-1:0] pred_meta,
  input  logic                            upd_valid,
  input  logic                            upd_taken,
  input  logic                            upd_mispredict,
  input  logic [HIST_BITS+INDEX_BITS-1:0] upd_meta,
  output logic [31:0]                     stat_branches,
  output logic [31:0]                     stat_mispredicts
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int META_BITS = HIST_BITS + INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_MIN  = {CTR_BITS{1'b0}};
  localparam logic [CTR_BITS-1:0] CTR_ONE  = {{(CTR_BITS-1){1'b0}}, 1'b1};

  logic [CTR_BITS-1:0]   pht_r [ENTRIES];
  logic [HIST_BITS-1:0]  ghr_r;
  logic [HIST_BITS-1:0]  ghr_next_s;
  logic [INDEX_BITS-1:0] hist_idx_s;
  logic [INDEX_BITS-1:0] pred_idx_s;
  logic [INDEX_BITS-1:0] upd_idx_s;
  logic [HIST_BITS-1:0]  upd_ghr_s;
  logic                  pred_taken_s;
  logic                  pred_fire_s;
  logic                  repair_s;
  logic [31:0]           stat_branches_r;
  logic [31:0]           stat_mispredicts_r;

  // Shift one outcome into a history value; works down to a 1-bit history.
  function automatic logic [HIST_BITS-1:0] hist_shift(input logic [HIST_BITS-1:0] h, input logic b);
    logic [HIST_BITS:0] wide;
    wide = {h, b};
    return wide[HIST_BITS-1:0];
  endfunction

  // Saturating up/down step of one PHT counter.
  function automatic logic [CTR_BITS-1:0] ctr_step(input logic [CTR_BITS-1:0] c, input logic taken);
    logic [CTR_BITS-1:0] n;
    if (taken) begin
      n = (c == CTR_MAX) ? c : c + CTR_ONE;
    end else begin
      n = (c == CTR_MIN) ? c : c - CTR_ONE;
    end
    return n;
  endfunction

  assign upd_idx_s = upd_meta[INDEX_BITS-1:0];
  assign upd_ghr_s = upd_meta[META_BITS-1:INDEX_BITS];
  assign repair_s  = upd_valid & upd_mispredict;
  assign pred_fire_s = pred_valid & ~pred_kill;

  // History contribution to the index, zero-extended; bimodal mode ignores it.
  always_comb begin
    hist_idx_s = '0;
    if (MODE != 0) begin
      hist_idx_s[HIST_BITS-1:0] = ghr_r;
    end else begin
      hist_idx_s = '0;
    end
  end

  assign pred_idx_s   = pred_pc[INDEX_BITS+1:2] ^ hist_idx_s;
  assign pred_taken_s = pred_fire_s & pht_r[pred_idx_s][CTR_BITS-1];
  assign pred_taken   = pred_taken_s;
  assign pred_meta    = {ghr_r, pred_idx_s};
  assign pred_target  = pred_pc + pred_offset;

  // Next history: repair from the resolved branch beats the speculative shift of a flushed ID slot.
  always_comb begin
    ghr_next_s = ghr_r;
    if (repair_s) begin
      ghr_next_s = hist_shift(upd_ghr_s, upd_taken);
    end else if (pred_fire_s) begin
      ghr_next_s = hist_shift(ghr_r, pred_taken_s);
    end else begin
      ghr_next_s = ghr_r;
    end
  end

  // Global history register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_r <= '0;
    end else begin
      ghr_r <= ghr_next_s;
    end
  end

  // PHT training from the entry recorded in the returned metadata; no read bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht_r[i] <= CTR_INIT;
      end
    end else if (upd_valid) begin
      pht_r[upd_idx_s] <= ctr_step(pht_r[upd_idx_s], upd_taken);
    end else begin
      pht_r[upd_idx_s] <= pht_r[upd_idx_s];
    end
  end

  // Resolved-branch and misprediction counters, free-running with wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_r    <= 32'd0;
      stat_mispredicts_r <= 32'd0;
    end else begin
      if (upd_valid) begin
        stat_branches_r <= stat_branches_r + 32'd1;
      end else begin
        stat_branches_r <= stat_branches_r;
      end
      if (repair_s) begin
        stat_mispredicts_r <= stat_mispredicts_r + 32'd1;
      end else begin
        stat_mispredicts_r <= stat_mispredicts_r;
      end
    end
  end

  assign stat_branches    = stat_branches_r;
  assign stat_mispredicts = stat_mispredicts_r;

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench: one bimodal and one gshare instance share stimulus; each task checks one feature.
module tb_gshare_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic        pred_valid, pred_kill;
  logic [31:0] pred_pc, pred_offset;
  logic        upd_valid, upd_taken, upd_mispredict;
  logic [11:0] upd_meta;

  logic [31:0] t0_target, t1_target;
  logic        t0_taken, t1_taken;
  logic [11:0] t0_meta, t1_meta;
  logic [31:0] t0_sb, t0_sm, t1_sb, t1_sm;

  int n_checks;
  int n_fail;

  gshare_branch_predictor #(.INDEX_BITS(6), .CTR_BITS(2), .HIST_BITS(6), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .pred_valid(pred_valid), .pred_kill(pred_kill),
    .pred_pc(pred_pc), .pred_offset(pred_offset), .pred_target(t0_target),
    .pred_taken(t0_taken), .pred_meta(t0_meta), .upd_valid(upd_valid),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict), .upd_meta(upd_meta),
    .stat_branches(t0_sb), .stat_mispredicts(t0_sm)
  );

  gshare_branch_predictor #(.INDEX_BITS(6), .CTR_BITS(2), .HIST_BITS(6), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .pred_valid(pred_valid), .pred_kill(pred_kill),
    .pred_pc(pred_pc), .pred_offset(pred_offset), .pred_target(t1_target),
    .pred_taken(t1_taken), .pred_meta(t1_meta), .upd_valid(upd_valid),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict), .upd_meta(upd_meta),
    .stat_branches(t1_sb), .stat_mispredicts(t1_sm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    pred_valid = 1'b0; pred_kill = 1'b0; pred_pc = 32'h0000_0040; pred_offset = 32'h0;
    upd_valid = 1'b0; upd_taken = 1'b0; upd_mispredict = 1'b0; upd_meta = 12'h000;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic upd(input logic t, input logic m, input logic [11:0] meta);
    upd_valid = 1'b1; upd_taken = t; upd_mispredict = m; upd_meta = meta;
    step();
    upd_valid = 1'b0; upd_taken = 1'b0; upd_mispredict = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    pred_valid = 1'b1; pred_pc = 32'h0000_0100; pred_offset = 32'h0000_0010;
    #2;
    n_checks++; if (t1_taken !== 1'b0) begin n_fail++; $display("FAIL rst_taken: got %b expected 0", t1_taken); end
    n_checks++; if (t1_meta !== 12'h000) begin n_fail++; $display("FAIL rst_meta: got %h expected 000", t1_meta); end
    n_checks++; if (t0_target !== 32'h0000_0110) begin n_fail++; $display("FAIL rst_target: got %h expected 00000110", t0_target); end
    pred_pc = 32'h0000_0104;
    #1;
    n_checks++; if (t1_meta !== 12'h001) begin n_fail++; $display("FAIL rst_meta_104: got %h expected 001", t1_meta); end
    step();
    rst_n = 1'b1;
    pred_pc = 32'h0000_0100;
    #1;
    n_checks++; if (t0_taken !== 1'b0 || t1_taken !== 1'b0) begin n_fail++; $display("FAIL rel_taken: got %b%b expected 00", t0_taken, t1_taken); end
    n_checks++; if (t1_sb !== 32'd0 || t1_sm !== 32'd0) begin n_fail++; $display("FAIL rel_stats: got %0d/%0d expected 0/0", t1_sb, t1_sm); end
    clear_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    pred_pc = 32'h0000_0040;
    upd(1'b1, 1'b0, 12'h010);
    pred_valid = 1'b1; #1;
    n_checks++; if (t0_taken !== 1'b1) begin n_fail++; $display("FAIL sat_t1: got %b expected 1", t0_taken); end
    pred_valid = 1'b0;
    upd(1'b1, 1'b0, 12'h010);
    upd(1'b1, 1'b0, 12'h010);
    upd(1'b1, 1'b0, 12'h010);
    pred_valid = 1'b1; #1;
    n_checks++; if (t0_taken !== 1'b1) begin n_fail++; $display("FAIL sat_t4: got %b expected 1", t0_taken); end
    pred_valid = 1'b0;
    upd(1'b0, 1'b0, 12'h010);
    pred_valid = 1'b1; #1;
    n_checks++; if (t0_taken !== 1'b1) begin n_fail++; $display("FAIL sat_nt1: got %b expected 1", t0_taken); end
    pred_valid = 1'b0;
    upd(1'b0, 1'b0, 12'h010);
    pred_valid = 1'b1; #1;
    n_checks++; if (t0_taken !== 1'b0) begin n_fail++; $display("FAIL sat_nt2: got %b expected 0", t0_taken); end
    pred_valid = 1'b0;
    upd(1'b0, 1'b0, 12'h010);
    upd(1'b0, 1'b0, 12'h010);
    upd(1'b1, 1'b0, 12'h010);
    pred_valid = 1'b1; #1;
    n_checks++; if (t0_taken !== 1'b0) begin n_fail++; $display("FAIL sat_low: got %b expected 0", t0_taken); end
    pred_valid = 1'b0;
    n_checks++; if (t0_sb !== 32'd9 || t0_sm !== 32'd0) begin n_fail++; $display("FAIL sat_stats: got %0d/%0d expected 9/0", t0_sb, t0_sm); end
    clear_inputs();
  endtask

  task automatic test_target();
    pred_pc = 32'hFFFF_FFF0; pred_offset = 32'h0000_0020; #1;
    n_checks++; if (t1_target !== 32'h0000_0010) begin n_fail++; $display("FAIL target_wrap: got %h expected 00000010", t1_target); end
    pred_pc = 32'h0000_0100; pred_offset = 32'hFFFF_FFFC; #1;
    n_checks++; if (t1_target !== 32'h0000_00FC) begin n_fail++; $display("FAIL target_neg: got %h expected 000000fc", t1_target); end
    clear_inputs();
  endtask

  task automatic test_gshare();
    do_reset();
    pred_valid = 1'b1; pred_pc = 32'h0000_0040; #1;
    n_checks++; if (t1_taken !== 1'b0 || t1_meta !== 12'h010) begin n_fail++; $display("FAIL gs_first: got %b/%h expected 0/010", t1_taken, t1_meta); end
    step();
    pred_valid = 1'b0; #1;
    n_checks++; if (t1_meta !== 12'h010) begin n_fail++; $display("FAIL gs_ghr0: got %h expected 010", t1_meta); end
    upd(1'b1, 1'b0, 12'h010);
    upd(1'b1, 1'b0, 12'h010);
    pred_valid = 1'b1; #1;
    n_checks++; if (t1_taken !== 1'b1) begin n_fail++; $display("FAIL gs_trained: got %b expected 1", t1_taken); end
    step();
    #1;
    n_checks++; if (t1_meta !== 12'h051) begin n_fail++; $display("FAIL gs_meta: got %h expected 051", t1_meta); end
    n_checks++; if (t1_taken !== 1'b0) begin n_fail++; $display("FAIL gs_newidx: got %b expected 0", t1_taken); end
    n_checks++; if (t0_meta !== 12'h050 || t0_taken !== 1'b1) begin n_fail++; $display("FAIL bim_meta: got %h/%b expected 050/1", t0_meta, t0_taken); end
    pred_valid = 1'b0;
    n_checks++; if (t1_sb !== 32'd2) begin n_fail++; $display("FAIL gs_stats: got %0d expected 2", t1_sb); end
    clear_inputs();
  endtask

  task automatic test_repair();
    do_reset();
    pred_valid = 1'b1; pred_pc = 32'h0000_0040;
    upd_valid = 1'b1; upd_mispredict = 1'b1; upd_taken = 1'b1; upd_meta = {6'b101010, 6'h05};
    step();
    clear_inputs();
    #1;
    n_checks++; if (t1_meta !== 12'h545) begin n_fail++; $display("FAIL rep_ghr: got %h expected 545", t1_meta); end
    n_checks++; if (t0_meta !== 12'h550) begin n_fail++; $display("FAIL rep_ghr_bim: got %h expected 550", t0_meta); end
    n_checks++; if (t1_sm !== 32'd1 || t1_sb !== 32'd1) begin n_fail++; $display("FAIL rep_stats: got %0d/%0d expected 1/1", t1_sb, t1_sm); end
    upd_mispredict = 1'b1; upd_meta = 12'h000;
    step();
    upd_mispredict = 1'b0; #1;
    n_checks++; if (t1_meta !== 12'h545) begin n_fail++; $display("FAIL ign_ghr: got %h expected 545", t1_meta); end
    n_checks++; if (t1_sm !== 32'd1 || t1_sb !== 32'd1) begin n_fail++; $display("FAIL ign_stats: got %0d/%0d expected 1/1", t1_sb, t1_sm); end
    pred_valid = 1'b1; #1;
    n_checks++; if (t1_taken !== 1'b1 || t0_taken !== 1'b0) begin n_fail++; $display("FAIL rep_ctr: got %b%b expected 10", t1_taken, t0_taken); end
    clear_inputs();
  endtask

  task automatic test_kill_hazard();
    do_reset();
    upd(1'b1, 1'b0, 12'h010);
    upd(1'b1, 1'b0, 12'h010);
    pred_valid = 1'b1; pred_kill = 1'b1; pred_pc = 32'h0000_0040; #1;
    n_checks++; if (t1_taken !== 1'b0 || t0_taken !== 1'b0) begin n_fail++; $display("FAIL kill_taken: got %b%b expected 00", t1_taken, t0_taken); end
    step();
    pred_kill = 1'b0; pred_valid = 1'b0; #1;
    n_checks++; if (t1_meta !== 12'h010) begin n_fail++; $display("FAIL kill_ghr: got %h expected 010", t1_meta); end
    upd(1'b0, 1'b0, 12'h010);
    upd_valid = 1'b1; upd_taken = 1'b0; upd_meta = 12'h010; pred_valid = 1'b1; #1;
    n_checks++; if (t1_taken !== 1'b1 || t0_taken !== 1'b1) begin n_fail++; $display("FAIL hz_old: got %b%b expected 11", t1_taken, t0_taken); end
    step();
    upd_valid = 1'b0; #1;
    n_checks++; if (t0_taken !== 1'b0) begin n_fail++; $display("FAIL hz_new: got %b expected 0", t0_taken); end
    n_checks++; if (t1_meta !== 12'h051) begin n_fail++; $display("FAIL hz_meta: got %h expected 051", t1_meta); end
    clear_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_saturation();
    test_target();
    test_gshare();
    test_repair();
    test_kill_hazard();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
